// File: rtl/pattern_serializer.sv
// pattern_serializer: takes a WIDTH-bit word plus a repeat count over valid/ready,
// shifts it out MSB first, and inserts GAP_BITS zero bits between frames.
module pattern_serializer #(
    parameter int WIDTH    = 4,
    parameter int GAP_BITS = 1,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_word,
    input  logic [CNT_W-1:0] in_reps,
    output logic             data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             done
);
    // One counter indexes pattern bits in SHIFT and gap bits in GAP;
    // 6 bits covers WIDTH up to 32 and GAP_BITS up to 15.
    localparam int BCW = 6;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [CNT_W-1:0] reps_q, reps_d;
    logic [BCW-1:0]   cnt_q, cnt_d;
    logic             data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    assign in_ready   = (state_q == IDLE) && !rst;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

    // Next-state and registered-output logic. The output flops always hold the
    // bit currently on the line, so the decision for the next bit is made here.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        word_d       = word_q;
        reps_d       = reps_q;
        cnt_d        = cnt_q;
        data_out_d   = 1'b0;
        data_valid_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d      = SHIFT;
                    word_d       = in_word;
                    shreg_d      = in_word;
                    reps_d       = in_reps;
                    cnt_d        = '0;
                    data_out_d   = in_word[WIDTH-1];
                    data_valid_d = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q != BCW'(WIDTH - 1)) begin
                    // Current bit sits at shreg_q[WIDTH-1]; the next one is below it.
                    shreg_d      = shreg_q << 1;
                    cnt_d        = cnt_q + 1'b1;
                    data_out_d   = shreg_q[WIDTH-2];
                    data_valid_d = 1'b1;
                    busy_d       = 1'b1;
                end else if (reps_q == '0) begin
                    state_d = IDLE;
                    shreg_d = '0;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else if (GAP_BITS > 0) begin
                    state_d      = GAP;
                    reps_d       = reps_q - 1'b1;
                    cnt_d        = '0;
                    data_valid_d = 1'b1;
                    busy_d       = 1'b1;
                end else begin
                    shreg_d      = word_q;
                    reps_d       = reps_q - 1'b1;
                    cnt_d        = '0;
                    data_out_d   = word_q[WIDTH-1];
                    data_valid_d = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            GAP: begin
                data_valid_d = 1'b1;
                busy_d       = 1'b1;
                if (cnt_q == BCW'(GAP_BITS - 1)) begin
                    state_d    = SHIFT;
                    shreg_d    = word_q;
                    cnt_d      = '0;
                    data_out_d = word_q[WIDTH-1];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset that overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            word_q       <= '0;
            reps_q       <= '0;
            cnt_q        <= '0;
            data_out_q   <= 1'b0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            word_q       <= word_d;
            reps_q       <= reps_d;
            cnt_q        <= cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end
endmodule
